turret_angle_ctrl: RTL and testbench

//  Parametrised turret aim controller; steps a turret through NUM_ANGLES discrete angles from keyboard keycodes.

---
 rtl/turret_angle_ctrl.sv | 158 +++++++++++++++
 tb/tb_turret_angle_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/turret_angle_ctrl.sv
// Turret aim controller: steps an aim index from keycode press edges and registers the per-angle table outputs.
// Optional hold-to-repeat is built when TURRET_AUTOREPEAT_EN is defined.
module turret_angle_ctrl #(
  parameter int NUM_ANGLES   = 9,
  parameter int HOME_IDX     = 4,
  parameter int COORD_W      = 10,
  parameter logic [7:0] KEY_CW  = 8'h51,
  parameter logic [7:0] KEY_CCW = 8'h52,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8,
  parameter logic [NUM_ANGLES*COORD_W-1:0] MX_TBL = {10'h000, 10'h3FF, 10'h3FF, 10'h3FE, 10'h3FF,
                                                      10'h3FE, 10'h3FF, 10'h3FF, 10'h000},
  parameter logic [NUM_ANGLES*COORD_W-1:0] MY_TBL = {10'h001, 10'h002, 10'h001, 10'h001, 10'h000,
                                                      10'h3FF, 10'h3FF, 10'h3FE, 10'h3FF},
  parameter logic [NUM_ANGLES*COORD_W-1:0] SX_TBL = {10'd545, 10'd516, 10'd514, 10'd513, 10'd510,
                                                      10'd535, 10'd550, 10'd549, 10'd558},
  parameter logic [NUM_ANGLES*COORD_W-1:0] SY_TBL = {10'd458, 10'd455, 10'd453, 10'd448, 10'd420,
                                                      10'd410, 10'd415, 10'd414, 10'd422}
) (
  input  logic                          clk2,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          step_en,
  output logic [$clog2(NUM_ANGLES)-1:0] angle_idx,
  output logic [NUM_ANGLES-1:0]         angle_onehot,
  output logic [COORD_W-1:0]            motion_x,
  output logic [COORD_W-1:0]            motion_y,
  output logic [COORD_W-1:0]            spawn_x,
  output logic [COORD_W-1:0]            spawn_y,
  output logic                          at_min,
  output logic                          at_max
);
  localparam int IDX_W = $clog2(NUM_ANGLES);
  localparam logic [IDX_W-1:0] HOME    = IDX_W'(HOME_IDX);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_ANGLES - 1);

  if (HOME_IDX >= NUM_ANGLES) begin : g_bad_home
    $error("turret_angle_ctrl: HOME_IDX must be below NUM_ANGLES");
  end

  function automatic logic [COORD_W-1:0] tbl_at(input logic [NUM_ANGLES*COORD_W-1:0] tbl,
                                                 input logic [IDX_W-1:0] i);
    return tbl[i*COORD_W +: COORD_W];
  endfunction

`ifdef TURRET_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_HELD_DELAY, S_HELD_REPEAT} state_t;
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
`else
  typedef enum logic [1:0] {S_IDLE, S_HELD} state_t;
  logic unused_step_en;
  assign unused_step_en = step_en;
`endif

  state_t                state_q, state_d;
  logic [7:0]            key_prev_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_ANGLES-1:0] onehot_q, onehot_d;
  logic [COORD_W-1:0]    mx_q, my_q, sx_q, sy_q;
  logic                  at_min_q, at_max_q;
  logic                  is_dir, press, step;

  always_comb begin
    is_dir  = (keycode == KEY_CW) || (keycode == KEY_CCW);
    press   = is_dir && (keycode != key_prev_q);
    step    = 1'b0;
    state_d = state_q;
`ifdef TURRET_AUTOREPEAT_EN
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
`endif
    if (state_q == S_IDLE) begin
      if (press) begin
        step = 1'b1;
`ifdef TURRET_AUTOREPEAT_EN
        state_d = S_HELD_DELAY;
        cnt_d   = '0;
`else
        state_d = S_HELD;
`endif
      end
    end else if (keycode != key_prev_q) begin
      // A switch straight to the other direction key is a fresh press.
      step = press;
`ifdef TURRET_AUTOREPEAT_EN
      cnt_d   = '0;
      state_d = press ? S_HELD_DELAY : S_IDLE;
`else
      state_d = press ? S_HELD : S_IDLE;
`endif
    end
`ifdef TURRET_AUTOREPEAT_EN
    else if (step_en) begin
      cnt_d = cnt_inc;
      if ((state_q == S_HELD_DELAY && cnt_inc == CNT_W'(REPEAT_DELAY)) ||
          (state_q == S_HELD_REPEAT && cnt_inc == CNT_W'(REPEAT_RATE))) begin
        step    = 1'b1;
        cnt_d   = '0;
        state_d = S_HELD_REPEAT;
      end
    end
`endif

    // Steps saturate at the end-stops rather than wrapping.
    idx_d = idx_q;
    if (step) begin
      if (keycode == KEY_CW) begin
        if (idx_q != IDX_MAX) idx_d = idx_q + 1'b1;
      end else if (idx_q != '0) begin
        idx_d = idx_q - 1'b1;
      end
    end
    onehot_d        = '0;
    onehot_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk2) begin
    key_prev_q <= keycode;
    if (!Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= HOME;
      onehot_q <= NUM_ANGLES'(1) << HOME_IDX;
      mx_q     <= tbl_at(MX_TBL, HOME);
      my_q     <= tbl_at(MY_TBL, HOME);
      sx_q     <= tbl_at(SX_TBL, HOME);
      sy_q     <= tbl_at(SY_TBL, HOME);
      at_min_q <= (HOME == '0);
      at_max_q <= (HOME == IDX_MAX);
`ifdef TURRET_AUTOREPEAT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      mx_q     <= tbl_at(MX_TBL, idx_d);
      my_q     <= tbl_at(MY_TBL, idx_d);
      sx_q     <= tbl_at(SX_TBL, idx_d);
      sy_q     <= tbl_at(SY_TBL, idx_d);
      at_min_q <= (idx_d == '0);
      at_max_q <= (idx_d == IDX_MAX);
`ifdef TURRET_AUTOREPEAT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign angle_idx    = idx_q;
  assign angle_onehot = onehot_q;
  assign motion_x     = mx_q;
  assign motion_y     = my_q;
  assign spawn_x      = sx_q;
  assign spawn_y      = sy_q;
  assign at_min       = at_min_q;
  assign at_max       = at_max_q;
endmodule

// File: tb/tb_turret_angle_ctrl.sv
// Directed bench for turret_angle_ctrl: reset state, single-step presses, end-stops, key switch,
// hold behaviour (auto-repeat when TURRET_AUTOREPEAT_EN is defined) and reset with a key held.
module tb_turret_angle_ctrl;
  logic       clk2 = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       step_en;
  logic [3:0] angle_idx;
  logic [8:0] angle_onehot;
  logic [9:0] motion_x, motion_y, spawn_x, spawn_y;
  logic       at_min, at_max;

  int checks   = 0;
  int failures = 0;

  turret_angle_ctrl #(.REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
    .clk2(clk2), .Reset(Reset), .keycode(keycode), .step_en(step_en),
    .angle_idx(angle_idx), .angle_onehot(angle_onehot),
    .motion_x(motion_x), .motion_y(motion_y), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .at_min(at_min), .at_max(at_max)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  logic [3:0] rep_exp [8];

  initial begin
    Reset   = 1'b0;
    keycode = 8'h00;
    step_en = 1'b0;

    // Test 1: reset state
    tick();
    tick();
    chk("rst_idx", angle_idx, 4);
    chk("rst_onehot", angle_onehot, 9'b000010000);
    chk("rst_mx", motion_x, 10'h3FF);
    chk("rst_my", motion_y, 10'h000);
    chk("rst_sx", spawn_x, 10'd510);
    chk("rst_sy", spawn_y, 10'd420);
    chk("rst_at_min", at_min, 0);
    chk("rst_at_max", at_max, 0);
    Reset = 1'b1;
    tick();
    chk("idle_idx", angle_idx, 4);

    // Test 2: a held key steps exactly once, on the sampling edge
    keycode = 8'h51;
    tick();
    chk("hold_first_edge", angle_idx, 5);
    for (int i = 0; i < 4; i++) tick();
    keycode = 8'h00;
    tick();
    chk("hold_idx", angle_idx, 5);
    chk("hold_onehot", angle_onehot, 9'b000100000);
    chk("hold_mx", motion_x, 10'h3FE);
    chk("hold_my", motion_y, 10'h001);
    chk("hold_sx", spawn_x, 10'd513);
    chk("hold_sy", spawn_y, 10'd448);

    // Test 3: ten CCW presses saturate at index 0
    do_reset();
    for (int i = 0; i < 4; i++) press(8'h52);
    chk("ccw4_idx", angle_idx, 0);
    for (int i = 0; i < 6; i++) press(8'h52);
    chk("ccw_idx", angle_idx, 0);
    chk("ccw_at_min", at_min, 1);
    chk("ccw_onehot", angle_onehot, 9'b000000001);
    chk("ccw_mx", motion_x, 10'h000);
    chk("ccw_my", motion_y, 10'h3FF);
    chk("ccw_sx", spawn_x, 10'd558);
    chk("ccw_sy", spawn_y, 10'd422);

    // Test 4: nine CW presses saturate at 8, then CW->CCW switch steps once
    do_reset();
    for (int i = 0; i < 9; i++) press(8'h51);
    chk("cw_idx", angle_idx, 8);
    chk("cw_at_max", at_max, 1);
    chk("cw_at_min", at_min, 0);
    chk("cw_sx", spawn_x, 10'd545);
    chk("cw_sy", spawn_y, 10'd458);
    keycode = 8'h51;
    tick();
    chk("cw_sat_idx", angle_idx, 8);
    keycode = 8'h52;
    tick();
    chk("switch_idx", angle_idx, 7);
    chk("switch_at_max", at_max, 0);
    tick();
    chk("switch_held_idx", angle_idx, 7);

    // Other keycodes never step; they re-arm a following direction key
    keycode = 8'h41;
    tick();
    chk("other_idx", angle_idx, 7);
    keycode = 8'h52;
    tick();
    chk("rearm_idx", angle_idx, 6);
    keycode = 8'h00;
    tick();

    // Test 5: hold with step_en every cycle
    do_reset();
`ifdef TURRET_AUTOREPEAT_EN
    rep_exp = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8};
`else
    rep_exp = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
`endif
    step_en = 1'b1;
    keycode = 8'h51;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk($sformatf("repeat_t%0d", t), angle_idx, rep_exp[t]);
    end
    keycode = 8'h00;
    tick();
    tick();
    chk("repeat_release_idx", angle_idx, rep_exp[7]);
    step_en = 1'b0;

    // Test 6: reset while a key is held, released with the key still down
    do_reset();
    keycode = 8'h52;
    tick();
    chk("pre_rst_idx", angle_idx, 3);
    Reset = 1'b0;
    tick();
    chk("mid_rst_idx", angle_idx, 4);
    Reset = 1'b1;
    tick();
    tick();
    chk("post_rst_idx", angle_idx, 4);
    keycode = 8'h00;
    tick();
    keycode = 8'h52;
    tick();
    chk("repress_idx", angle_idx, 3);
    keycode = 8'h00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
